// File: rtl/gp_mem_arbiter_pkg.sv
// Shared definitions for the graphics-pipeline DRAM arbiter: FSM state
// encodings, requester ids, DRAM command polarity and burst geometry.
package gp_mem_arbiter_pkg;

    // DRAM-side geometry: 31-bit burst address, two 128-bit beats per burst.
    localparam int ADDR_W         = 31;
    localparam int BEAT_W         = 128;
    localparam int MASK_W         = 16;
    localparam int GP_BURST_BEATS = 2;

    // Number of requesters sharing the round-robin tier (GP, FF, LE).
    localparam int RR_N = 3;

    // gp command defines: value driven on af_rnw for each access type.
    localparam logic GP_CMD_RD = 1'b1;
    localparam logic GP_CMD_WR = 1'b0;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WBEAT2 = 3'd2,
        ST_RBEAT1 = 3'd3,
        ST_RBEAT2 = 3'd4
    } arb_state_t;

    // Requester ids.
    typedef enum logic [1:0] {
        REQ_PF = 2'd0,
        REQ_GP = 2'd1,
        REQ_FF = 2'd2,
        REQ_LE = 2'd3
    } req_id_t;

    // PF and GP are the read clients; FF and LE write.
    function automatic logic is_read(input req_id_t id);
        return (id == REQ_PF) || (id == REQ_GP);
    endfunction

endpackage

// File: rtl/gp_mem_arbiter_rr_arb3.sv
// Three-way round-robin arbiter. Bit 0 = GP, bit 1 = FF, bit 2 = LE.
// The grant is purely combinational from the current pointer; on i_adv the
// pointer moves to the requester after the one currently granted.
module rr_arb3
    import gp_mem_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [RR_N-1:0] i_req,
    input  logic            i_adv,
    output logic [RR_N-1:0] o_gnt
);

    logic [1:0] r_ptr;

    // Pick the first requester at or after the pointer, wrapping around.
    always_comb begin
        o_gnt = '0;
        case (r_ptr)
            2'd0: begin
                if      (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
            2'd1: begin
                if      (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            2'd2: begin
                if      (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            default: o_gnt = '0;
        endcase
    end

    // Pointer starts at GP and moves past the winner when the top accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (i_adv) begin
            if      (o_gnt[0]) r_ptr <= 2'd1;
            else if (o_gnt[1]) r_ptr <= 2'd2;
            else if (o_gnt[2]) r_ptr <= 2'd0;
        end
    end

endmodule

// File: rtl/gp_mem_arbiter.sv
// DRAM arbiter for the graphics pipeline. Four clients share one DRAM
// controller port: PF and GP read, FF and LE write, each as a 2-beat burst.
// PF has priority but is capped at PF_BURST_MAX back-to-back grants while
// anyone else waits; GP/FF/LE share a round-robin tier. Only one burst is
// in flight at a time, so read beats always belong to the latched owner.
module gp_mem_arbiter
    import gp_mem_arbiter_pkg::*;
#(
    parameter int PF_BURST_MAX = 8
) (
    input  logic                clk,
    input  logic                rst,
    // pixel feeder (read)
    input  logic                pf_req,
    input  logic [ADDR_W-1:0]   pf_addr,
    output logic                pf_gnt,
    output logic                pf_rd_valid,
    // command fetch (read)
    input  logic                gp_req,
    input  logic [ADDR_W-1:0]   gp_addr,
    output logic                gp_gnt,
    output logic                gp_rd_valid,
    // frame filler (write)
    input  logic                ff_req,
    input  logic [ADDR_W-1:0]   ff_addr,
    input  logic [2*BEAT_W-1:0] ff_wdata,
    input  logic [2*MASK_W-1:0] ff_wmask,
    output logic                ff_gnt,
    // line engine (write)
    input  logic                le_req,
    input  logic [ADDR_W-1:0]   le_addr,
    input  logic [2*BEAT_W-1:0] le_wdata,
    input  logic [2*MASK_W-1:0] le_wmask,
    output logic                le_gnt,
    // shared read data
    output logic [BEAT_W-1:0]   rd_data,
    // DRAM controller side
    input  logic                af_full,
    input  logic                wdf_full,
    input  logic                rdf_valid,
    input  logic [BEAT_W-1:0]   rdf_dout,
    output logic                af_wr_en,
    output logic                af_rnw,
    output logic [ADDR_W-1:0]   af_addr_din,
    output logic                wdf_wr_en,
    output logic [BEAT_W-1:0]   wdf_din,
    output logic [MASK_W-1:0]   wdf_mask_din,
    output logic                rdf_rd_en
);

    localparam int              CNT_W   = $clog2(PF_BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PF_BURST_MAX);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    req_id_t             r_id;
    req_id_t             w_win_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [BEAT_W-1:0]   r_wdata_hi;
    logic [MASK_W-1:0]   r_wmask_hi;
    logic [CNT_W-1:0]    r_pf_cnt;

    logic                w_any_req;
    logic                w_others;
    logic                w_pf_wins;
    logic                w_latch;
    logic                w_rr_adv;
    logic [RR_N-1:0]     w_rr_req;
    logic [RR_N-1:0]     w_rr_gnt;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [BEAT_W-1:0]   w_win_wdata_hi;
    logic [MASK_W-1:0]   w_win_wmask_hi;
    logic [BEAT_W-1:0]   w_wdata_lo;
    logic [MASK_W-1:0]   w_wmask_lo;
    logic                w_gnt_any;
    logic                w_rd_beat;

    assign w_any_req = pf_req | gp_req | ff_req | le_req;
    assign w_others  = gp_req | ff_req | le_req;
    assign w_rr_req  = {le_req, ff_req, gp_req};

    // PF loses only once it has used up its burst allowance and someone waits.
    assign w_pf_wins = pf_req && !((r_pf_cnt == CNT_MAX) && w_others);
    assign w_latch   = (r_state == ST_IDLE) && w_any_req;
    assign w_rr_adv  = (r_state == ST_IDLE) && w_others && !w_pf_wins;

    rr_arb3 u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_rr_req),
        .i_adv (w_rr_adv),
        .o_gnt (w_rr_gnt)
    );

    // Winner selection and the request fields that travel with it.
    always_comb begin
        w_win_id = REQ_PF;
        if (!w_pf_wins) begin
            if      (w_rr_gnt[1]) w_win_id = REQ_FF;
            else if (w_rr_gnt[2]) w_win_id = REQ_LE;
            else                  w_win_id = REQ_GP;
        end
        case (w_win_id)
            REQ_PF:  w_win_addr = pf_addr;
            REQ_GP:  w_win_addr = gp_addr;
            REQ_FF:  w_win_addr = ff_addr;
            default: w_win_addr = le_addr;
        endcase
        w_win_wdata_hi = (w_win_id == REQ_LE) ? le_wdata[2*BEAT_W-1:BEAT_W] : ff_wdata[2*BEAT_W-1:BEAT_W];
        w_win_wmask_hi = (w_win_id == REQ_LE) ? le_wmask[2*MASK_W-1:MASK_W] : ff_wmask[2*MASK_W-1:MASK_W];
    end

    // Beat 0 is taken live: the writer holds its data until it sees gnt.
    assign w_wdata_lo = (r_id == REQ_LE) ? le_wdata[BEAT_W-1:0] : ff_wdata[BEAT_W-1:0];
    assign w_wmask_lo = (r_id == REQ_LE) ? le_wmask[MASK_W-1:0] : ff_wmask[MASK_W-1:0];

    // State register and owner id.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_id    <= REQ_PF;
        end else begin
            r_state <= w_state_nxt;
            if (w_latch) r_id <= w_win_id;
        end
    end

    // Capture address and beat-1 payload when the winner is chosen.
    always_ff @(posedge clk) begin
        if (w_latch) begin
            r_addr     <= w_win_addr;
            r_wdata_hi <= w_win_wdata_hi;
            r_wmask_hi <= w_win_wmask_hi;
        end
    end

    // PF back-to-back grant counter: saturating, cleared by any other grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pf_cnt <= '0;
        end else if (w_gnt_any) begin
            if (r_id == REQ_PF) begin
                if (r_pf_cnt != CNT_MAX) r_pf_cnt <= r_pf_cnt + CNT_W'(1);
            end else begin
                r_pf_cnt <= '0;
            end
        end
    end

    // Next-state and DRAM-side strobes; everything idles at 0 and under rst.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_any    = 1'b0;
        w_rd_beat    = 1'b0;
        af_wr_en     = 1'b0;
        af_rnw       = 1'b0;
        af_addr_din  = '0;
        wdf_wr_en    = 1'b0;
        wdf_din      = '0;
        wdf_mask_din = '0;
        rdf_rd_en    = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) w_state_nxt = ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (is_read(r_id)) begin
                        if (!af_full) begin
                            af_wr_en    = 1'b1;
                            af_rnw      = GP_CMD_RD;
                            af_addr_din = r_addr;
                            w_gnt_any   = 1'b1;
                            w_state_nxt = ST_RBEAT1;
                        end
                    end else if (!af_full && !wdf_full) begin
                        // Command and first beat go in together so the
                        // controller never sees a write without its data.
                        af_wr_en     = 1'b1;
                        af_rnw       = GP_CMD_WR;
                        af_addr_din  = r_addr;
                        wdf_wr_en    = 1'b1;
                        wdf_din      = w_wdata_lo;
                        wdf_mask_din = w_wmask_lo;
                        w_gnt_any    = 1'b1;
                        w_state_nxt  = ST_WBEAT2;
                    end
                end
                ST_WBEAT2: begin
                    if (!wdf_full) begin
                        wdf_wr_en    = 1'b1;
                        wdf_din      = r_wdata_hi;
                        wdf_mask_din = r_wmask_hi;
                        w_state_nxt  = ST_IDLE;
                    end
                end
                ST_RBEAT1: begin
                    rdf_rd_en = rdf_valid;
                    w_rd_beat = rdf_valid;
                    if (rdf_valid) w_state_nxt = ST_RBEAT2;
                end
                ST_RBEAT2: begin
                    rdf_rd_en = rdf_valid;
                    w_rd_beat = rdf_valid;
                    if (rdf_valid) w_state_nxt = ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign pf_gnt      = w_gnt_any && (r_id == REQ_PF);
    assign gp_gnt      = w_gnt_any && (r_id == REQ_GP);
    assign ff_gnt      = w_gnt_any && (r_id == REQ_FF);
    assign le_gnt      = w_gnt_any && (r_id == REQ_LE);
    assign pf_rd_valid = w_rd_beat && (r_id == REQ_PF);
    assign gp_rd_valid = w_rd_beat && (r_id == REQ_GP);
    assign rd_data     = rst ? '0 : rdf_dout;

endmodule

// File: tb/tb_gp_mem_arbiter.sv
// Directed bench for gp_mem_arbiter with a scoreboard of expected DRAM
// commands, write beats and read beats checked by a negedge monitor.
module tb_gp_mem_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic         pf_req, gp_req, ff_req, le_req;
    logic [30:0]  pf_addr, gp_addr, ff_addr, le_addr;
    logic [255:0] ff_wdata, le_wdata;
    logic [31:0]  ff_wmask, le_wmask;
    logic         pf_gnt, gp_gnt, ff_gnt, le_gnt;
    logic         pf_rd_valid, gp_rd_valid;
    logic [127:0] rd_data;
    logic         af_full, wdf_full, rdf_valid;
    logic [127:0] rdf_dout;
    logic         af_wr_en, af_rnw, wdf_wr_en, rdf_rd_en;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    int n_chk  = 0;
    int n_fail = 0;
    int n_af   = 0;

    logic [35:0]  q_af[$];
    logic [143:0] q_wd[$];
    logic [129:0] q_rd[$];

    localparam logic [127:0] BEAT_A = {4{32'hAAAA_0001}};
    localparam logic [127:0] BEAT_B = {4{32'hBBBB_0002}};
    localparam logic [127:0] BEAT_D = {4{32'h1234_5678}};

    always #5 clk = ~clk;

    gp_mem_arbiter #(.PF_BURST_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .pf_req(pf_req), .pf_addr(pf_addr), .pf_gnt(pf_gnt), .pf_rd_valid(pf_rd_valid),
        .gp_req(gp_req), .gp_addr(gp_addr), .gp_gnt(gp_gnt), .gp_rd_valid(gp_rd_valid),
        .ff_req(ff_req), .ff_addr(ff_addr), .ff_wdata(ff_wdata), .ff_wmask(ff_wmask), .ff_gnt(ff_gnt),
        .le_req(le_req), .le_addr(le_addr), .le_wdata(le_wdata), .le_wmask(le_wmask), .le_gnt(le_gnt),
        .rd_data(rd_data),
        .af_full(af_full), .wdf_full(wdf_full), .rdf_valid(rdf_valid), .rdf_dout(rdf_dout),
        .af_wr_en(af_wr_en), .af_rnw(af_rnw), .af_addr_din(af_addr_din),
        .wdf_wr_en(wdf_wr_en), .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din),
        .rdf_rd_en(rdf_rd_en)
    );

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [319:0] outs();
        return 320'({pf_gnt, pf_rd_valid, gp_gnt, gp_rd_valid, ff_gnt, le_gnt,
                     af_wr_en, af_rnw, wdf_wr_en, rdf_rd_en,
                     af_addr_din, wdf_din, wdf_mask_din, rd_data});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read: one command with the owner's grant, then two beats.
    task automatic exp_rd(input logic pf, input logic [30:0] addr,
                          input logic [127:0] d0, input logic [127:0] d1);
        q_af.push_back({(pf ? 4'b1000 : 4'b0100), 1'b1, addr});
        q_rd.push_back({pf, ~pf, d0});
        q_rd.push_back({pf, ~pf, d1});
    endtask

    // Expected write: command with beat 0 (low half), then beat 1 (high half).
    task automatic exp_wr(input logic le, input logic [30:0] addr,
                          input logic [255:0] data, input logic [31:0] mask);
        q_af.push_back({(le ? 4'b0001 : 4'b0010), 1'b0, addr});
        q_wd.push_back({mask[15:0], data[127:0]});
        q_wd.push_back({mask[31:16], data[255:128]});
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        pf_req = 1'b0; gp_req = 1'b0; ff_req = 1'b0; le_req = 1'b0;
        pf_addr = '0; gp_addr = '0; ff_addr = '0; le_addr = '0;
        ff_wdata = '0; le_wdata = '0; ff_wmask = '0; le_wmask = '0;
        af_full = 1'b0; wdf_full = 1'b0; rdf_valid = 1'b0; rdf_dout = '0;
        tick();
        tick();
        @(negedge clk);
        chk("outputs_during_rst", outs(), 320'(0));
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("outputs_after_rst", outs(), 320'(0));
        tick();
    endtask

    task automatic wait_af(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            if (af_wr_en) got++;
            cyc++;
        end
        chk("grant_count", 320'(got), 320'(n));
        tick();
    endtask

    // Scoreboard monitor: every DRAM-side event must match the next expectation.
    always @(negedge clk) begin : mon
        logic [3:0]   g;
        logic [35:0]  e_af;
        logic [143:0] e_wd;
        logic [129:0] e_rd;
        g = {pf_gnt, gp_gnt, ff_gnt, le_gnt};
        chk("gnt_without_af", 320'(g & {4{~af_wr_en}}), 320'(0));
        chk("rdvalid_without_rden", 320'({pf_rd_valid, gp_rd_valid} & {2{~rdf_rd_en}}), 320'(0));
        if (af_wr_en) begin
            n_af++;
            chk("af_expected", 320'(q_af.size() != 0), 320'(1));
            if (q_af.size() != 0) begin
                e_af = q_af.pop_front();
                chk("af_cmd", 320'({g, af_rnw, af_addr_din}), 320'(e_af));
            end
        end
        if (wdf_wr_en) begin
            chk("wd_expected", 320'(q_wd.size() != 0), 320'(1));
            if (q_wd.size() != 0) begin
                e_wd = q_wd.pop_front();
                chk("wd_beat", 320'({wdf_mask_din, wdf_din}), 320'(e_wd));
            end
        end
        if (rdf_rd_en) begin
            chk("rd_expected", 320'(q_rd.size() != 0), 320'(1));
            if (q_rd.size() != 0) begin
                e_rd = q_rd.pop_front();
                chk("rd_beat", 320'({pf_rd_valid, gp_rd_valid, rd_data}), 320'(e_rd));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n0;

        // GP read alone: grant in cycle 2, two beats owned by GP.
        reset_dut();
        exp_rd(1'b0, 31'h100, BEAT_A, BEAT_B);
        gp_req = 1'b1; gp_addr = 31'h100;
        @(negedge clk); chk("s1_gnt_cycle1", 320'(gp_gnt), 320'(0));
        tick();
        @(negedge clk); chk("s1_gnt_cycle2", 320'(gp_gnt), 320'(1));
        tick(); gp_req = 1'b0; rdf_valid = 1'b1; rdf_dout = BEAT_A;
        tick(); rdf_dout = BEAT_B;
        tick(); rdf_valid = 1'b0; rdf_dout = '0;
        tick(); tick();

        // FF write held off by wdf_full, then low beat and high beat in order.
        reset_dut();
        n0 = n_af;
        wdf_full = 1'b1;
        ff_req = 1'b1; ff_addr = 31'h2000;
        ff_wdata = {{4{32'hC0DE_0011}}, {4{32'h0000_FACE}}};
        ff_wmask = 32'hF0F0_0FFF;
        exp_wr(1'b0, 31'h2000, ff_wdata, ff_wmask);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk); chk("s2_no_af_while_wdf_full", 320'(af_wr_en), 320'(0));
        end
        tick(); wdf_full = 1'b0;
        @(negedge clk); chk("s2_gnt_after_wdf_free", 320'(ff_gnt), 320'(1));
        tick(); ff_req = 1'b0;
        tick(); tick();
        chk("s2_single_af", 320'(n_af - n0), 320'(1));

        // GP, FF, LE all requesting: round-robin GP, FF, LE, GP, FF, LE.
        reset_dut();
        rdf_valid = 1'b1; rdf_dout = BEAT_D;
        gp_req = 1'b1; gp_addr = 31'h3100;
        ff_req = 1'b1; ff_addr = 31'h3200;
        ff_wdata = {{4{32'hF1F1_0002}}, {4{32'hF1F1_0001}}}; ff_wmask = 32'h1234_5678;
        le_req = 1'b1; le_addr = 31'h3300;
        le_wdata = {{4{32'hE1E1_0002}}, {4{32'hE1E1_0001}}}; le_wmask = 32'h9ABC_DEF0;
        for (int r = 0; r < 2; r++) begin
            exp_rd(1'b0, 31'h3100, BEAT_D, BEAT_D);
            exp_wr(1'b0, 31'h3200, ff_wdata, ff_wmask);
            exp_wr(1'b1, 31'h3300, le_wdata, le_wmask);
        end
        wait_af(6, 60);
        gp_req = 1'b0; ff_req = 1'b0; le_req = 1'b0;
        tick(); tick(); tick(); tick();
        rdf_valid = 1'b0; rdf_dout = '0;

        // PF and GP continuous: 8 PF grants then one GP grant, twice.
        reset_dut();
        rdf_valid = 1'b1; rdf_dout = BEAT_D;
        pf_req = 1'b1; pf_addr = 31'h300;
        gp_req = 1'b1; gp_addr = 31'h400;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) exp_rd(1'b1, 31'h300, BEAT_D, BEAT_D);
            exp_rd(1'b0, 31'h400, BEAT_D, BEAT_D);
        end
        wait_af(18, 120);
        pf_req = 1'b0; gp_req = 1'b0;
        tick(); tick(); tick(); tick();
        rdf_valid = 1'b0; rdf_dout = '0;

        // rst during RBEAT1 abandons the read; next PF request behaves normally.
        reset_dut();
        q_af.push_back({4'b1000, 1'b1, 31'h500});
        pf_req = 1'b1; pf_addr = 31'h500;
        @(negedge clk);
        tick();
        @(negedge clk); chk("s5_first_gnt", 320'(pf_gnt), 320'(1));
        tick(); pf_req = 1'b0; rst = 1'b1;
        @(negedge clk); chk("s5_outputs_in_rst", outs(), 320'(0));
        tick(); rst = 1'b0;
        @(negedge clk); chk("s5_outputs_after_rst", outs(), 320'(0));
        tick();
        exp_rd(1'b1, 31'h540, BEAT_A, BEAT_B);
        pf_req = 1'b1; pf_addr = 31'h540;
        @(negedge clk); chk("s5_new_gnt_cycle1", 320'(pf_gnt), 320'(0));
        tick();
        @(negedge clk); chk("s5_new_gnt_cycle2", 320'(pf_gnt), 320'(1));
        tick(); pf_req = 1'b0; rdf_valid = 1'b1; rdf_dout = BEAT_A;
        tick(); rdf_dout = BEAT_B;
        tick(); rdf_valid = 1'b0; rdf_dout = '0;
        tick();

        // af_full for 5 ISSUE cycles: PF grant moves from cycle 2 to cycle 7.
        reset_dut();
        n0 = n_af;
        af_full = 1'b1;
        exp_rd(1'b1, 31'h600, BEAT_B, BEAT_A);
        pf_req = 1'b1; pf_addr = 31'h600;
        @(negedge clk); chk("s6_gnt_cycle1", 320'(pf_gnt), 320'(0));
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk); chk("s6_gnt_held_by_af_full", 320'(pf_gnt), 320'(0));
        end
        tick(); af_full = 1'b0;
        @(negedge clk); chk("s6_gnt_cycle7", 320'(pf_gnt), 320'(1));
        tick(); pf_req = 1'b0; rdf_valid = 1'b1; rdf_dout = BEAT_B;
        tick(); rdf_dout = BEAT_A;
        tick(); rdf_valid = 1'b0; rdf_dout = '0;
        tick(); tick();
        chk("s6_single_af", 320'(n_af - n0), 320'(1));

        chk("af_queue_drained", 320'(q_af.size()), 320'(0));
        chk("wd_queue_drained", 320'(q_wd.size()), 320'(0));
        chk("rd_queue_drained", 320'(q_rd.size()), 320'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
